// File: rtl/subtractor.sv
`default_nettype none
// ============================================================================
// Module      : subtractor
// Description : Registered two's-complement subtractor (A - B) with carry-out
//               (no-borrow) and Overflow/Zero/Negative flags, valid-qualified.
// Revision    : 1.0 - initial release
// ============================================================================
module subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    output logic [WIDTH-1:0] Diff,
    output logic             Cout,
    output logic             Overflow,
    output logic             Zero,
    output logic             Negative
);

    localparam int MSB = WIDTH - 1;

    logic [WIDTH:0]   sum_d;
    logic [WIDTH-1:0] diff_d;
    logic             cout_d;
    logic             ovf_d;
    logic             zero_d;
    logic             neg_d;

    logic             valid_q;
    logic [WIDTH-1:0] diff_q;
    logic             cout_q;
    logic             ovf_q;
    logic             zero_q;
    logic             neg_q;

    always_comb begin
        sum_d  = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
        diff_d = sum_d[WIDTH-1:0];
        cout_d = sum_d[WIDTH];
        ovf_d  = (A[MSB] != B[MSB]) && (diff_d[MSB] != A[MSB]);
        // Flags are registered alongside Diff so they read 0 out of reset.
        zero_d = (diff_d == '0);
        neg_d  = diff_d[MSB];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            diff_q  <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                diff_q <= diff_d;
                cout_q <= cout_d;
                ovf_q  <= ovf_d;
                zero_q <= zero_d;
                neg_q  <= neg_d;
            end
        end
    end

    assign out_valid = valid_q;
    assign Diff      = diff_q;
    assign Cout      = cout_q;
    assign Overflow  = ovf_q;
    assign Zero      = zero_q;
    assign Negative  = neg_q;

endmodule
`default_nettype wire

// File: tb/tb_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_subtractor
// Description : Self-checking bench for subtractor against an integer model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         out_valid;
    logic [W-1:0] Diff;
    logic         Cout;
    logic         Overflow;
    logic         Zero;
    logic         Negative;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: what the outputs should show after the last edge.
    logic         m_valid;
    logic [W-1:0] m_diff;
    logic         m_cout;
    logic         m_ovf;
    logic         m_zero;
    logic         m_neg;

    subtractor #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .A        (A),
        .B        (B),
        .out_valid(out_valid),
        .Diff     (Diff),
        .Cout     (Cout),
        .Overflow (Overflow),
        .Zero     (Zero),
        .Negative (Negative)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_update(input logic r, input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
        int sa, sb, sd, ua, ub;
        if (r) begin
            m_valid = 0; m_diff = '0; m_cout = 0; m_ovf = 0; m_zero = 0; m_neg = 0;
        end else if (v) begin
            sa = $signed(a);
            sb = $signed(b);
            ua = int'(a);
            ub = int'(b);
            sd = sa - sb;
            m_valid = 1;
            m_diff  = W'(sd);
            m_cout  = (ua >= ub);
            m_ovf   = (sd > (2**(W-1)) - 1) || (sd < -(2**(W-1)));
            m_zero  = (sa == sb);
            m_neg   = (m_diff[W-1] == 1'b1);
        end else begin
            m_valid = 0;
        end
    endtask

    task automatic step(input string tag, input logic r, input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
        rst = r; in_valid = v; A = a; B = b;
        @(posedge clk);
        #1;
        model_update(r, v, a, b);
        check({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
        check({tag, ".diff"},  32'(Diff),      32'(m_diff));
        check({tag, ".cout"},  32'(Cout),      32'(m_cout));
        check({tag, ".ovf"},   32'(Overflow),  32'(m_ovf));
        check({tag, ".zero"},  32'(Zero),      32'(m_zero));
        check({tag, ".neg"},   32'(Negative),  32'(m_neg));
    endtask

    initial begin
        rst = 1; in_valid = 0; A = '0; B = '0;
        m_valid = 0; m_diff = '0; m_cout = 0; m_ovf = 0; m_zero = 0; m_neg = 0;

        step("rst0", 1, 1, 8'd69, 8'd42);
        step("rst1", 1, 1, 8'd69, 8'd42);
        check("rst_diff_const", 32'(Diff), 32'd0);
        step("idle0", 0, 0, 8'd69, 8'd42);
        step("idle1", 0, 0, 8'd0, 8'd0);

        step("basic", 0, 1, 8'd69, 8'd42);
        check("basic_diff_const", 32'(Diff), 32'd27);
        step("borrow", 0, 1, 8'd42, 8'd69);
        check("borrow_diff_const", 32'(Diff), 32'hE5);
        step("borrow2", 0, 1, 8'd0, 8'd127);
        check("borrow2_diff_const", 32'(Diff), 32'h81);
        step("ovf_neg", 0, 1, 8'h80, 8'd1);
        check("ovf_neg_const", 32'({Diff, Overflow, Cout}), 32'({8'h7F, 1'b1, 1'b1}));
        step("ovf_pos", 0, 1, 8'd127, 8'hFF);
        check("ovf_pos_const", 32'({Diff, Overflow, Cout}), 32'({8'h80, 1'b1, 1'b0}));
        step("zero", 0, 1, 8'd5, 8'd5);
        check("zero_const", 32'({Zero, Cout}), 32'({1'b1, 1'b1}));
        step("bzero", 0, 1, 8'hA3, 8'd0);

        for (int i = 0; i < 4; i++)
            step("stream", 0, 1, W'($urandom), W'($urandom));
        step("drop", 0, 0, W'($urandom), W'($urandom));
        step("drop2", 0, 0, W'($urandom), W'($urandom));

        for (int i = 0; i < 40; i++)
            step("rand", 0, ($urandom_range(0, 3) != 0), W'($urandom), W'($urandom));

        step("mid0", 0, 1, 8'd100, 8'd3);
        step("midrst", 1, 1, 8'd9, 8'd2);
        step("after", 0, 0, 8'd9, 8'd2);
        step("resume", 0, 1, 8'h80, 8'h7F);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/subtractor.md
Name: subtractor

Overview:
- Registered two's-complement subtractor: Diff = A - B, plus carry-out (no-borrow) and status flags.
- Used as a functional unit in the datapath ALU.
- One-cycle latency, valid-qualified, width-parameterized (default 8-bit signed).

Parameters:
- WIDTH, 8, operand and result width in bits; operands and result are signed two's complement.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  A/B are valid this cycle and are captured.
- A  input  WIDTH  minuend, signed.
- B  input  WIDTH  subtrahend, signed.
- out_valid  output  1  Diff/Cout/flags hold the result of an accepted operation.
- Diff  output  WIDTH  A - B, modulo 2^WIDTH, signed.
- Cout  output  1  carry-out of A + ~B + 1; 1 = no borrow (A >= B unsigned), 0 = borrow.
- Overflow  output  1  signed overflow of the subtraction.
- Zero  output  1  Diff == 0.
- Negative  output  1  Diff[WIDTH-1].

Behaviour:
- Reset:
  - Sync, active-high, one clock and reset; rst sampled on clk rising edge.
  - While rst=1 at an edge: out_valid=0, Diff=0, Cout=0, Overflow=0, Zero=0, Negative=0.
  - Reset overrides in_valid in the same cycle; an operation presented then is dropped.
- Arithmetic:
  - Computed as A + (~B) + 1 over WIDTH+1 bits.
  - Diff = low WIDTH bits; Cout = bit WIDTH.
  - Overflow = (A[msb] != B[msb]) && (Diff[msb] != A[msb]).
  - Zero and Negative are derived from the registered Diff.
- Operand decode: no sign extension beyond WIDTH; unsigned interpretation is valid via Cout.
- Latency:
  - Edge with in_valid=1 and rst=0: all result outputs and out_valid=1 update together, visible after that edge.
  - Edge with in_valid=0 and rst=0: out_valid=0. Diff/Cout/flags hold their previous values; no new computation is latched.
- Throughput: one operation per cycle. Back-to-back in_valid yields back-to-back out_valid, each result matching its own operands.
- No backpressure: the consumer must take results the cycle out_valid is high.
- Boundaries:
  - A == B gives Diff=0, Zero=1, Cout=1.
  - B=0 gives Diff=A, Cout=1, Overflow=0.
  - Most-negative minus positive, or positive minus negative, may wrap; Overflow flags it, and Diff is the wrapped value (no saturation).
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset: drive rst=1 with in_valid=1, A=69, B=42 for 2 cycles -> out_valid=0, Diff=0, Cout=0, all flags 0. Deassert rst, idle -> outputs stay 0.
- Basic: A=69, B=42, in_valid=1 -> next edge Diff=27, Cout=1, Overflow=0, Zero=0, Negative=0, out_valid=1.
- Borrow: A=42, B=69 -> Diff=-27 (0xE5), Cout=0, Negative=1, Overflow=0.
- Then A=0, B=127 -> Diff=-127 (0x81), Cout=0, Negative=1, Overflow=0.
- Overflow:
  - A=-128, B=1 -> Diff=127 (0x7F), Overflow=1, Cout=1.
  - A=127, B=-1 -> Diff=-128 (0x80), Overflow=1, Cout=0.
- Zero and streaming:
  - A=5, B=5 -> Diff=0, Zero=1, Cout=1.
  - Four back-to-back random pairs -> four consecutive out_valid results, each equal to the golden A-B.
  - Then drop in_valid -> out_valid=0 with Diff holding the last value.
  - Assert rst mid-stream -> outputs clear next edge.
